// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MEM/WB inputs, decode read ports, PC-load and retire outputs.
// master = pipeline side (drives MEM/WB and read indices), slave = wb_regfile.
interface wb_regfile_if #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned CNT_BITS = 32
);
    logic [BITS-1:0]     ALUOutW;
    logic [BITS-1:0]     ReadDataW;
    logic                MemtoRegW;
    logic                RegWriteW;
    logic                PCSrcW;
    logic [3:0]          WA3W;
    logic [3:0]          RA1D;
    logic [3:0]          RA2D;
    logic [BITS-1:0]     PCPlus8D;
    logic [BITS-1:0]     RD1D;
    logic [BITS-1:0]     RD2D;
    logic [BITS-1:0]     ResultW;
    logic                PCLoadW;
    logic [CNT_BITS-1:0] RetireCnt;

    modport master (
        output ALUOutW, ReadDataW, MemtoRegW, RegWriteW, PCSrcW,
        output WA3W, RA1D, RA2D, PCPlus8D,
        input  RD1D, RD2D, ResultW, PCLoadW, RetireCnt
    );

    modport slave (
        input  ALUOutW, ReadDataW, MemtoRegW, RegWriteW, PCSrcW,
        input  WA3W, RA1D, RA2D, PCPlus8D,
        output RD1D, RD2D, ResultW, PCLoadW, RetireCnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage + register file R0..R14 (R15 = PC, never stored) with retire counter.
// Ports: CLK, RESET (sync, active-low), bus (wb_regfile_if.slave). Macro: WB_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned NREGS    = 15,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    wb_regfile_if.slave  bus
);
    logic [BITS-1:0]     rf [NREGS];
    logic [CNT_BITS-1:0] cnt;
    logic [BITS-1:0]     result;
    logic                wr_en;
    logic                retire;
    logic                byp1;
    logic                byp2;
    logic [BITS-1:0]     rd1;
    logic [BITS-1:0]     rd2;

    assign result = bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;

    // R15 is the PC: such writes only raise PCLoadW.
    assign wr_en  = RESET && bus.RegWriteW && (bus.WA3W != 4'hF);
    assign retire = RESET && (bus.RegWriteW || bus.PCSrcW);

`ifdef WB_BYPASS_EN
    // Write-through so decode sees this cycle's writeback without a stall.
    assign byp1 = RESET && bus.RegWriteW &&
                  (bus.WA3W == bus.RA1D) && (bus.RA1D != 4'hF);
    assign byp2 = RESET && bus.RegWriteW &&
                  (bus.WA3W == bus.RA2D) && (bus.RA2D != 4'hF);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        for (int i = 0; i < int'(NREGS); i++) begin
            if (!RESET) begin
                rf[i] <= '0;
            end else if (wr_en && (bus.WA3W == 4'(i))) begin
                rf[i] <= result;
            end
        end
    end

    // Saturating: the all-ones value is sticky until reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (retire && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (bus.RA1D == 4'(i)) rd1 = rf[i];
            if (bus.RA2D == 4'(i)) rd2 = rf[i];
        end
        unique case (1'b1)
            (bus.RA1D == 4'hF): rd1 = bus.PCPlus8D;
            byp1:               rd1 = result;
            default:            ;
        endcase
        unique case (1'b1)
            (bus.RA2D == 4'hF): rd2 = bus.PCPlus8D;
            byp2:               rd2 = result;
            default:            ;
        endcase
    end

    assign bus.RD1D      = rd1;
    assign bus.RD2D      = rd2;
    assign bus.ResultW   = result;
    assign bus.PCLoadW   = RESET & bus.PCSrcW;
    assign bus.RetireCnt = cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile (32-bit counter plus a 4-bit counter instance).
// Driver pushes expected outputs per cycle; monitor pops and compares on negedge.
module tb_wb_regfile;
    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    wb_regfile_if #(.BITS(32), .CNT_BITS(32)) bus ();
    wb_regfile_if #(.BITS(32), .CNT_BITS(4))  bus4 ();

    assign bus4.ALUOutW   = bus.ALUOutW;
    assign bus4.ReadDataW = bus.ReadDataW;
    assign bus4.MemtoRegW = bus.MemtoRegW;
    assign bus4.RegWriteW = bus.RegWriteW;
    assign bus4.PCSrcW    = bus.PCSrcW;
    assign bus4.WA3W      = bus.WA3W;
    assign bus4.RA1D      = bus.RA1D;
    assign bus4.RA2D      = bus.RA2D;
    assign bus4.PCPlus8D  = bus.PCPlus8D;

    wb_regfile #(.BITS(32), .NREGS(15), .CNT_BITS(32)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    wb_regfile #(.BITS(32), .NREGS(15), .CNT_BITS(4)) u_dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus4)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic        pcl;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] m_rf [15];
    longint      m_cnt;
    int          m_cnt4;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input logic rst,
                                           input logic we, input logic [3:0] wa,
                                           input logic [31:0] res,
                                           input logic [31:0] pc8);
        if (a == 4'hF) return pc8;
`ifdef WB_BYPASS_EN
        if (rst && we && (wa == a)) return res;
`else
        if (rst && we && (wa == a) && 1'b0) return res;
`endif
        return m_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 15; i++) m_rf[i] = 32'h0;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    // One pipeline cycle: drive, predict the pre-edge outputs, then apply edge effects.
    task automatic cyc(input logic rst, input logic we, input logic m2r,
                       input logic pcs, input logic [3:0] wa,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [3:0] a1, input logic [3:0] a2,
                       input logic [31:0] pc8);
        exp_t        e;
        logic [31:0] res;
        RESET         = rst;
        bus.RegWriteW = we;
        bus.MemtoRegW = m2r;
        bus.PCSrcW    = pcs;
        bus.WA3W      = wa;
        bus.ALUOutW   = alu;
        bus.ReadDataW = rdat;
        bus.RA1D      = a1;
        bus.RA2D      = a2;
        bus.PCPlus8D  = pc8;
        res    = m2r ? rdat : alu;
        e.res  = res;
        e.pcl  = rst & pcs;
        e.rd1  = exp_rd(a1, rst, we, wa, res, pc8);
        e.rd2  = exp_rd(a2, rst, we, wa, res, pc8);
        e.cnt  = m_cnt[31:0];
        e.cnt4 = m_cnt4[3:0];
        q.push_back(e);
        if (!rst) begin
            model_clear();
        end else begin
            if (we && (wa != 4'hF)) m_rf[wa] = res;
            if (we || pcs) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("RD1D", bus.RD1D, e.rd1);
            chk("RD2D", bus.RD2D, e.rd2);
            chk("ResultW", bus.ResultW, e.res);
            chk("PCLoadW", {31'b0, bus.PCLoadW}, {31'b0, e.pcl});
            chk("RetireCnt", bus.RetireCnt, e.cnt);
            chk("RetireCnt4", {28'b0, bus4.RetireCnt}, {28'b0, e.cnt4});
        end
    end

    initial begin
        logic [3:0]  wa;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        rst;
        RESET         = 1'b0;
        bus.RegWriteW = 1'b0;
        bus.MemtoRegW = 1'b0;
        bus.PCSrcW    = 1'b0;
        bus.WA3W      = 4'h0;
        bus.ALUOutW   = 32'h0;
        bus.ReadDataW = 32'h0;
        bus.RA1D      = 4'h0;
        bus.RA2D      = 4'h0;
        bus.PCPlus8D  = 32'h0;
        model_clear();
        @(posedge CLK);
        #1;

        // reset state
        cyc(1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h3, 4'hF, 32'h108);
        // ALU writeback then read
        cyc(1, 1, 0, 0, 4'h5, 32'hDEADBEEF, 32'h0, 4'h5, 4'h0, 32'h108);
        cyc(1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h5, 4'h5, 32'h108);
        // load writeback with same-cycle read
        cyc(1, 1, 1, 0, 4'h2, 32'h9999, 32'h1234, 4'h5, 4'h2, 32'h10C);
        cyc(1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h2, 4'h2, 32'h10C);
        // write to R15: PC load only
        cyc(1, 1, 0, 1, 4'hF, 32'h200, 32'h0, 4'hF, 4'h2, 32'h110);
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'(i), 4'(i + 8), 32'h300);
        // write dropped by reset on the same edge
        cyc(1, 1, 0, 0, 4'h7, 32'h5555, 32'h0, 4'h7, 4'h7, 32'h0);
        cyc(0, 1, 0, 0, 4'h7, 32'hAAAA, 32'h0, 4'h7, 4'h5, 32'h0);
        cyc(1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h7, 4'h5, 32'h0);
        // saturation of the 4-bit counter instance
        for (int i = 0; i < 20; i++)
            cyc(1, 1, 0, 0, 4'(i % 15), 32'(i * 3), 32'h0, 4'(i % 15), 4'hF, 32'h40);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            wa  = 4'($urandom_range(0, 15));
            a1  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            a2  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            cyc(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), wa, $urandom, $urandom,
                a1, a2, $urandom);
        end

        repeat (2) @(posedge CLK);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
